// File: rtl/qec_rep_decoder.sv
// Multi-round syndrome decoder for a distance-DISTANCE bit-flip repetition code.
// It majority-votes ROUNDS syndromes per stabilizer and then emits a minimum-weight correction mask.
module qec_rep_decoder #(
  parameter int DISTANCE = 3,
  parameter int ROUNDS   = 3,
  parameter int CNT_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DISTANCE-2:0]             i_syn_in,
  input  logic                            i_syn_valid,
  output logic                            o_syn_ready,
  input  logic                            i_single_shot,
  input  logic                            i_flush,
  output logic [DISTANCE-1:0]             o_corr,
  output logic [$clog2(DISTANCE+1)-1:0]   o_corr_weight,
  output logic                            o_error_detected,
  output logic                            o_inconsistent,
  output logic                            o_corr_valid,
  input  logic                            i_corr_ready,
  input  logic                            i_clr_stats,
  output logic [CNT_W-1:0]                o_err_count
);

  localparam int S    = DISTANCE - 1;
  localparam int OW   = $clog2(ROUNDS + 1);
  localparam int WW   = $clog2(DISTANCE + 1);
  localparam int HALF = (DISTANCE - 1) / 2;

  if ((DISTANCE < 3) || (DISTANCE % 2 == 0) || (ROUNDS < 1) || (ROUNDS % 2 == 0) || (CNT_W < 1)) begin : g_bad_params
    $error("qec_rep_decoder: DISTANCE must be odd >= 3, ROUNDS odd >= 1, CNT_W >= 1");
  end

  typedef enum logic [1:0] {ST_ACCUM, ST_DECODE, ST_OUTPUT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [OW-1:0]      r_round_cnt;
  logic               r_ss_q;
  logic [DISTANCE-1:0] r_corr;
  logic [WW-1:0]      r_corr_weight;
  logic               r_error_detected;
  logic               r_inconsistent;
  logic [CNT_W-1:0]   r_err_count;

  logic               w_accum;
  logic               w_take;
  logic               w_clear;
  logic               w_last;
  logic               w_ss_eff;
  logic [OW-1:0]      w_reff_in;
  logic [OW-1:0]      w_reff_q;
  logic [S-1:0]       w_vote;
  logic [S-1:0]       w_mixed;
  logic [DISTANCE-1:0] w_e;
  logic [DISTANCE-1:0] w_corr;

  function automatic logic [WW-1:0] popcnt(input logic [DISTANCE-1:0] x);
    logic [WW-1:0] sum;
    sum = '0;
    for (int k = 0; k < DISTANCE; k++) sum = sum + WW'(x[k]);
    return sum;
  endfunction

  assign w_accum   = (r_state == ST_ACCUM);
  assign w_take    = w_accum & i_syn_valid & ~i_flush;
  assign w_clear   = (w_accum & i_flush) | (r_state == ST_DECODE);
  // The first round of a decode uses the live single_shot, later rounds the latched copy.
  assign w_ss_eff  = (r_round_cnt == '0) ? i_single_shot : r_ss_q;
  assign w_reff_in = w_ss_eff ? OW'(1) : OW'(ROUNDS);
  assign w_reff_q  = r_ss_q ? OW'(1) : OW'(ROUNDS);
  assign w_last    = w_take && ((r_round_cnt + OW'(1)) == w_reff_in);

  genvar gi;
  for (gi = 0; gi < S; gi++) begin : g_stab
    logic [OW-1:0] r_ones;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ones <= '0;
      end else if (w_clear) begin
        r_ones <= '0;
      end else if (w_take) begin
        r_ones <= r_ones + OW'(i_syn_in[gi]);
      end
    end
    assign w_vote[gi]  = {r_ones, 1'b0} > {1'b0, w_reff_q};
    assign w_mixed[gi] = (r_ones != '0) && (r_ones != w_reff_q);
  end

  // Chain the voted syndrome into a qubit error pattern, then keep the lighter of it and its complement.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_e    = '0;
    for (int k = 0; k < S; k++) begin
      acc      = acc ^ w_vote[k];
      w_e[k+1] = acc;
    end
    w_corr = (popcnt(w_e) > WW'(HALF)) ? ~w_e : w_e;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_last) w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = ST_OUTPUT;
      ST_OUTPUT: if (i_corr_ready) w_state_next = ST_ACCUM;
      default:   w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_round_cnt <= '0;
      r_ss_q      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_round_cnt <= '0;
      end else if (w_take) begin
        r_round_cnt <= r_round_cnt + OW'(1);
        if (r_round_cnt == '0) r_ss_q <= i_single_shot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr           <= '0;
      r_corr_weight    <= '0;
      r_error_detected <= 1'b0;
      r_inconsistent   <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_corr           <= w_corr;
      r_corr_weight    <= popcnt(w_corr);
      r_error_detected <= |w_vote;
      r_inconsistent   <= |w_mixed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (i_clr_stats) begin
      r_err_count <= '0;
    end else if ((r_state == ST_OUTPUT) && i_corr_ready && r_error_detected && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign o_syn_ready      = w_accum & ~rst;
  assign o_corr           = r_corr;
  assign o_corr_weight    = r_corr_weight;
  assign o_error_detected = r_error_detected;
  assign o_inconsistent   = r_inconsistent;
  assign o_corr_valid     = (r_state == ST_OUTPUT);
  assign o_err_count      = r_err_count;

endmodule

// File: tb/tb_qec_rep_decoder.sv
// Randomized self-checking bench for qec_rep_decoder: a D=3/R=3/CNT_W=2 instance and a D=5/R=1 instance.
// Expected corrections come from a brute-force minimum-weight search over all qubit error patterns.
module tb_qec_rep_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] a_syn_in = '0;
  logic       a_syn_valid = 0, a_syn_ready, a_ss = 0, a_flush = 0;
  logic [2:0] a_corr;
  logic [1:0] a_wt;
  logic       a_err, a_inc, a_cv, a_cr = 0, a_clr = 0;
  logic [1:0] a_cnt;

  logic [3:0] b_syn_in = '0;
  logic       b_syn_valid = 0, b_syn_ready, b_ss = 0, b_flush = 0;
  logic [4:0] b_corr;
  logic [2:0] b_wt;
  logic       b_err, b_inc, b_cv, b_cr = 0, b_clr = 0;
  logic [7:0] b_cnt;

  qec_rep_decoder #(.DISTANCE(3), .ROUNDS(3), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .i_syn_in(a_syn_in), .i_syn_valid(a_syn_valid), .o_syn_ready(a_syn_ready),
    .i_single_shot(a_ss), .i_flush(a_flush), .o_corr(a_corr), .o_corr_weight(a_wt),
    .o_error_detected(a_err), .o_inconsistent(a_inc), .o_corr_valid(a_cv), .i_corr_ready(a_cr),
    .i_clr_stats(a_clr), .o_err_count(a_cnt));

  qec_rep_decoder #(.DISTANCE(5), .ROUNDS(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .i_syn_in(b_syn_in), .i_syn_valid(b_syn_valid), .o_syn_ready(b_syn_ready),
    .i_single_shot(b_ss), .i_flush(b_flush), .o_corr(b_corr), .o_corr_weight(b_wt),
    .o_error_detected(b_err), .o_inconsistent(b_inc), .o_corr_valid(b_cv), .i_corr_ready(b_cr),
    .i_clr_stats(b_clr), .o_err_count(b_cnt));

  int n_checks = 0;
  int n_errors = 0;
  int a_exp_cnt = 0;
  int b_exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lightest qubit flip pattern whose parity checks reproduce the voted syndrome.
  function automatic logic [7:0] ref_corr(input int d, input logic [7:0] vs);
    int best = 0;
    int bw = 99;
    int mask = (1 << (d - 1)) - 1;
    for (int m = 0; m < (1 << d); m++) begin
      int s = (m ^ (m >> 1)) & mask;
      if ((s == int'(vs)) && ($countones(m) < bw)) begin
        best = m;
        bw = $countones(m);
      end
    end
    return 8'(best);
  endfunction

  task automatic a_push(input logic [1:0] s, input logic ss);
    bit hs = 0;
    a_syn_in = s;
    a_syn_valid = 1;
    a_ss = ss;
    for (int k = 0; k < 40 && !hs; k++) begin
      hs = a_syn_ready;
      @(negedge clk);
    end
    a_syn_valid = 0;
    a_ss = 1'($urandom % 2);
    if (!hs) check("a_push_timeout", 0, 1);
  endtask

  task automatic a_run(input logic [1:0] r0, r1, r2, input bit ss, input int dly, input bit clr);
    logic [1:0] rs [3];
    logic [7:0] v = 0;
    logic [7:0] ec;
    bit inc = 0;
    int n = ss ? 1 : 3;
    rs[0] = r0; rs[1] = r1; rs[2] = r2;
    for (int i = 0; i < 2; i++) begin
      int c = 0;
      for (int j = 0; j < n; j++) c += int'(rs[j][i]);
      v[i] = (2 * c > n);
      if (c != 0 && c != n) inc = 1;
    end
    ec = ref_corr(3, v);
    for (int j = 0; j < n; j++) a_push(rs[j], (j == 0) ? logic'(ss) : logic'($urandom % 2));
    check("a_lat1_valid", 32'(a_cv), 0);
    @(negedge clk);
    check("a_lat2_valid", 32'(a_cv), 1);
    check("a_corr", 32'(a_corr), 32'(ec));
    check("a_weight", 32'(a_wt), $countones(ec));
    check("a_err_det", 32'(a_err), 32'(v != 0));
    check("a_inconsistent", 32'(a_inc), 32'(inc));
    for (int k = 0; k < dly; k++) begin
      a_syn_valid = 1;
      a_syn_in = 2'($urandom);
      @(negedge clk);
      check("a_stall_ready", 32'(a_syn_ready), 0);
      check("a_stall_valid", 32'(a_cv), 1);
      check("a_stall_corr", 32'(a_corr), 32'(ec));
    end
    a_syn_valid = 0;
    a_cr = 1;
    a_clr = clr;
    @(negedge clk);
    a_cr = 0;
    a_clr = 0;
    if (clr) a_exp_cnt = 0;
    else if (v != 0 && a_exp_cnt < 3) a_exp_cnt++;
    check("a_err_count", 32'(a_cnt), a_exp_cnt);
    check("a_valid_drop", 32'(a_cv), 0);
    check("a_corr_hold", 32'(a_corr), 32'(ec));
  endtask

  task automatic b_run(input logic [3:0] s);
    logic [7:0] ec;
    bit hs = 0;
    ec = ref_corr(5, 8'(s));
    b_syn_in = s;
    b_syn_valid = 1;
    for (int k = 0; k < 40 && !hs; k++) begin
      hs = b_syn_ready;
      @(negedge clk);
    end
    b_syn_valid = 0;
    if (!hs) check("b_push_timeout", 0, 1);
    check("b_lat1_valid", 32'(b_cv), 0);
    @(negedge clk);
    check("b_lat2_valid", 32'(b_cv), 1);
    check("b_corr", 32'(b_corr), 32'(ec));
    check("b_weight", 32'(b_wt), $countones(ec));
    check("b_err_det", 32'(b_err), 32'(s != 0));
    check("b_inconsistent", 32'(b_inc), 0);
    b_cr = 1;
    @(negedge clk);
    b_cr = 0;
    if (s != 0 && b_exp_cnt < 255) b_exp_cnt++;
    check("b_err_count", 32'(b_cnt), b_exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_a", 32'(a_syn_ready), 0);
    check("rst_ready_b", 32'(b_syn_ready), 0);
    check("rst_outs_a", {a_corr, a_wt, a_err, a_inc, a_cv, a_cnt}, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(a_syn_ready), 1);
    $display("phase directed D=3");
    a_run(2'b01, 2'b01, 2'b01, 0, 0, 0);
    check("plan_01x3_corr", 32'(a_corr), 32'b001);
    a_run(2'b11, 2'b00, 2'b11, 0, 0, 0);
    check("plan_11_00_11_corr", 32'(a_corr), 32'b010);
    check("plan_11_00_11_inc", 32'(a_inc), 1);
    a_run(2'b10, 2'b00, 2'b00, 0, 0, 0);
    check("plan_10_00_00_corr", 32'(a_corr), 32'b000);
    check("plan_10_00_00_err", 32'(a_err), 0);
    a_run(2'b10, 2'b00, 2'b00, 1, 0, 0);
    check("plan_ss_corr", 32'(a_corr), 32'b100);
    a_run(2'b01, 2'b01, 2'b01, 0, 0, 0);
    a_push(2'b11, 0);
    a_push(2'b11, 0);
    a_flush = 1;
    a_syn_valid = 1;
    a_syn_in = 2'b11;
    @(negedge clk);
    a_flush = 0;
    a_syn_valid = 0;
    a_run(2'b00, 2'b00, 2'b00, 0, 0, 0);
    check("plan_flush_corr", 32'(a_corr), 0);
    check("plan_flush_inc", 32'(a_inc), 0);
    a_run(2'b01, 2'b10, 2'b01, 0, 10, 0);
    a_run(2'b01, 2'b01, 2'b01, 0, 0, 1);
    for (int i = 0; i < 5; i++) a_run(2'b01, 2'b01, 2'b01, 0, 0, 0);
    check("plan_sat_cnt", 32'(a_cnt), 3);
    a_run(2'b01, 2'b01, 2'b01, 0, 0, 1);
    check("plan_clr_wins", 32'(a_cnt), 0);
    $display("phase directed D=5");
    b_run(4'b0011);
    check("plan_b_0011", 32'(b_corr), 32'b00010);
    b_run(4'b1000);
    check("plan_b_1000", 32'(b_corr), 32'b10000);
    b_run(4'b0000);
    check("plan_b_0000", 32'(b_corr), 0);
    $display("phase random");
    for (int i = 0; i < 60; i++)
      a_run(2'($urandom), 2'($urandom), 2'($urandom), ($urandom % 4) == 0,
            int'($urandom % 3), ($urandom % 10) == 0);
    for (int i = 0; i < 30; i++) b_run(4'($urandom));
    $display("phase reset mid-decode");
    a_run(2'b01, 2'b01, 2'b01, 0, 0, 0);
    a_push(2'b01, 0);
    a_syn_valid = 1;
    a_syn_in = 2'b01;
    rst = 1;
    #1;
    check("midrst_ready", 32'(a_syn_ready), 0);
    check("midrst_outs", {a_corr, a_wt, a_err, a_inc, a_cv, a_cnt}, 0);
    check("midrst_b_cnt", 32'(b_cnt), 0);
    @(negedge clk);
    rst = 0;
    a_syn_valid = 0;
    a_exp_cnt = 0;
    b_exp_cnt = 0;
    @(negedge clk);
    a_run(2'b10, 2'b10, 2'b00, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
